mmio_io_bank: RTL

//  Responder for memory bank 2 (MMIO window 0xFFFF0000-0xFFFF000C). Sits behind the
//  CPU address decoder: takes its bank enable (memEn[2]), the 13-bit physical offset
//  and the read/write strobes. Implements four word registers: keyboard receive

---
 rtl/mmio_io_bank.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mmio_io_bank.sv
// MMIO responder for bank 2: keyboard receive FIFO (RCR/RDR) and display transmit
// register (TCR/TDR) with valid/ready handshake and a level interrupt.
module mmio_io_bank #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [12:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] SEL_RCR = 2'd0;
  localparam logic [1:0] SEL_RDR = 2'd1;
  localparam logic [1:0] SEL_TCR = 2'd2;
  localparam logic [1:0] SEL_TDR = 2'd3;

  typedef enum logic {TX_IDLE, TX_BUSY} txState_t;

  logic             access;
  logic             wrStrobe;
  logic             rdStrobe;
  logic [1:0]       regSel;
  logic             tdrWrite;

  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             rxRdy;
  logic             push;
  logic             pop;

  logic             ieR;
  logic             ieT;
  logic             ovr;
  txState_t         txState;
  logic             txValidQ;
  logic [7:0]       txDataQ;
  logic             txRdy;

  logic             unusedWdata;

  // A combined read+write strobe is treated as a write only, so it never pops.
  assign access   = en & (memRead | memWrite) & (addr[1:0] == 2'b00) & (addr <= 13'hC);
  assign wrStrobe = access & memWrite;
  assign rdStrobe = access & memRead & ~memWrite;
  assign regSel   = addr[3:2];
  assign tdrWrite = wrStrobe & (regSel == SEL_TDR);

  assign rxRdy     = (count != '0);
  assign kbd_ready = (count != CNT_FULL);
  assign push      = kbd_valid & kbd_ready;
  assign pop       = rdStrobe & (regSel == SEL_RDR) & rxRdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      if (push & ~pop)      count <= count + CNT_ONE;
      else if (pop & ~push) count <= count - CNT_ONE;
    end
  end

  // Storage is only observable while count is non-zero, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= kbd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ieR <= 1'b0;
      ieT <= 1'b0;
    end else if (wrStrobe) begin
      if (regSel == SEL_RCR) ieR <= wdata[1];
      if (regSel == SEL_TCR) ieT <= wdata[1];
    end
  end

  // Busy-state TDR writes are rejected using tx_valid as seen before the edge,
  // including the edge on which the handshake completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txState  <= TX_IDLE;
      txValidQ <= 1'b0;
      txDataQ  <= '0;
      ovr      <= 1'b0;
    end else begin
      if (wrStrobe && (regSel == SEL_TCR) && wdata[2]) ovr <= 1'b0;
      case (txState)
        TX_IDLE: begin
          if (tdrWrite) begin
            txDataQ  <= wdata[7:0];
            txValidQ <= 1'b1;
            txState  <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tdrWrite) ovr <= 1'b1;
          if (tx_ready) begin
            txValidQ <= 1'b0;
            txState  <= TX_IDLE;
          end
        end
      endcase
    end
  end

  assign txRdy    = ~txValidQ;
  assign tx_valid = txValidQ;
  assign tx_data  = txDataQ;
  assign irq      = (ieR & rxRdy) | (ieT & txRdy);

  always_comb begin
    rdata = '0;
    if (rdStrobe) begin
      case (regSel)
        SEL_RCR: rdata = {29'b0, 1'b0, ieR, rxRdy};
        SEL_RDR: rdata = rxRdy ? {24'b0, fifoMem[rdPtr]} : '0;
        SEL_TCR: rdata = {29'b0, ovr, ieT, txRdy};
        default: rdata = {24'b0, txDataQ};
      endcase
    end
  end

  assign unusedWdata = ^wdata[31:8];

endmodule
